// File: rtl/lcd_receiver_if.sv
// lcd_receiver_if: LCD serial pins toward the receiver and decoded results back
interface lcd_receiver_if;
    logic       lcde;
    logic       lcdrs;
    logic       lcdrw;
    logic       lcddat;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       rx_valid;
    logic       busy;
    logic       init_seen;
    logic       frame_err;
    logic       overrun_err;
    modport master (
        output lcde, lcdrs, lcdrw, lcddat,
        input  rx_data, rx_rs, rx_valid, busy, init_seen, frame_err, overrun_err
    );
    modport slave (
        input  lcde, lcdrs, lcdrw, lcddat,
        output rx_data, rx_rs, rx_valid, busy, init_seen, frame_err, overrun_err
    );
endinterface

// File: rtl/lcd_receiver.sv
// lcd_receiver: serial LCD byte receiver with busy window, idle timeout and init detection
module lcd_receiver #(
    parameter int BUSY_CYCLES    = 40,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic           clk,
    input logic           reset,
    lcd_receiver_if.slave bus
);
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT_CYCLES);

    logic          lcde_q, lcdrs_q, lcdrw_q, lcddat_q;
    logic [6:0]    sr;
    logic [2:0]    cnt;
    logic          rs_held;
    logic [TW-1:0] idle;
    logic [BW-1:0] busy_cnt;
    logic [1:0]    init_idx;
    logic [7:0]    rx_data;
    logic          rx_rs, rx_valid, init_seen, frame_err, overrun_err;
    logic          fall, busy, bad, timeout, take, rs_clash, accept, done;
    logic [7:0]    byte_in, init_exp;

    // edge detection and bit acceptance; a timeout outranks a coincident bit
    always_comb begin
        fall     = lcde_q & ~bus.lcde;
        busy     = busy_cnt != '0;
        bad      = busy | lcdrw_q;
        timeout  = cnt != 3'd0 && idle == IDLE_MAX;
        take     = fall & ~bad & ~timeout;
        rs_clash = take && cnt != 3'd0 && lcdrs_q != rs_held;
        accept   = take & ~rs_clash;
        done     = accept && cnt == 3'd7;
        byte_in  = {sr, lcddat_q};
        init_exp = init_idx == 2'd0 ? 8'h38 : init_idx == 2'd1 ? 8'h0C : init_idx == 2'd2 ? 8'h01 : 8'h06;
    end

    // single register stage on the LCD pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {lcde_q, lcdrs_q, lcdrw_q, lcddat_q} <= '0;
        else        {lcde_q, lcdrs_q, lcdrw_q, lcddat_q} <= {bus.lcde, bus.lcdrs, bus.lcdrw, bus.lcddat};
    end

    // shift bits in MSB first; the 8th bit goes straight into rx_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            cnt     <= '0;
            rs_held <= 1'b0;
            rx_data <= '0;
            rx_rs   <= 1'b0;
        end else if (timeout || rs_clash) begin
            cnt <= '0;
        end else if (accept) begin
            sr  <= byte_in[6:0];
            cnt <= cnt + 3'd1;
            if (cnt == 3'd0) rs_held <= lcdrs_q;
            if (done) begin
                rx_data <= byte_in;
                rx_rs   <= rs_held;
            end
        end
    end

    // idle counter counts cycles since the last accepted bit of a partial byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                idle <= '0;
        else if (accept)           idle <= TW'(1);
        else if (cnt == 3'd0)      idle <= '0;
        else if (idle != IDLE_MAX) idle <= idle + TW'(1);
    end

    // post-byte busy window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    busy_cnt <= '0;
        else if (done) busy_cnt <= BUSY_LOAD;
        else if (busy) busy_cnt <= busy_cnt - BW'(1);
    end

    // one-cycle status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_valid    <= done;
            frame_err   <= timeout | rs_clash;
            overrun_err <= fall & bad;
        end
    end

    // init sequence matcher over command bytes only; a stray 0x38 restarts at index 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_idx  <= '0;
            init_seen <= 1'b0;
        end else if (done && !rs_held) begin
            if (byte_in == init_exp) begin
                init_idx <= init_idx + 2'd1;
                if (init_idx == 2'd3) init_seen <= 1'b1;
            end else begin
                init_idx <= byte_in == 8'h38 ? 2'd1 : 2'd0;
            end
        end
    end

    assign bus.rx_data     = rx_data;
    assign bus.rx_rs       = rx_rs;
    assign bus.rx_valid    = rx_valid;
    assign bus.busy        = busy;
    assign bus.init_seen   = init_seen;
    assign bus.frame_err   = frame_err;
    assign bus.overrun_err = overrun_err;
endmodule

// File: tb/tb_lcd_receiver.sv
// tb_lcd_receiver: randomized and directed checks of lcd_receiver against a timestamp-based model
module tb_lcd_receiver;
    localparam int BUSY = 40;
    localparam int TMO  = 1000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    lcd_receiver_if bus();

    lcd_receiver #(.BUSY_CYCLES(BUSY), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // bit delivery announced by the driver for the edge where the receiver sees the fall
    logic ev = 1'b0, ev_bit = 1'b0, ev_rs = 1'b0, ev_rw = 1'b0;

    // model state: cycle timestamps instead of counters, byte history for init
    int          cyc = 0, m_cnt = 0, m_acc = 0, m_last = 0, m_done = 0;
    bit          m_have = 0, m_rs = 0;
    logic [31:0] m_hist = '0;
    logic        e_valid = 0, e_ferr = 0, e_oerr = 0, e_rs = 0, e_busy = 0, e_init = 0;
    logic [7:0]  e_data = '0;

    int nv = 0, nf = 0, no = 0, run = 0, last_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_have = 0; m_hist = '0;
        e_valid = 0; e_ferr = 0; e_oerr = 0; e_rs = 0; e_busy = 0; e_init = 0; e_data = '0;
    endtask

    // behavioural reference model
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            model_clear();
        end else begin
            bit busy_in, tmo;
            cyc++;
            e_valid = 0; e_ferr = 0; e_oerr = 0;
            busy_in = m_have && (cyc - m_done) >= 1 && (cyc - m_done) <= BUSY;
            tmo = m_cnt > 0 && (cyc - m_last) == TMO;
            if (tmo) begin
                e_ferr = 1; m_cnt = 0;
            end
            if (ev && (busy_in || ev_rw)) begin
                e_oerr = 1;
            end else if (ev && !tmo) begin
                if (m_cnt > 0 && ev_rs != m_rs) begin
                    e_ferr = 1; m_cnt = 0;
                end else begin
                    if (m_cnt == 0) begin m_rs = ev_rs; m_acc = 0; end
                    m_acc = m_acc * 2 + int'(ev_bit);
                    m_cnt++;
                    m_last = cyc;
                    if (m_cnt == 8) begin
                        e_valid = 1; e_data = m_acc[7:0]; e_rs = m_rs;
                        m_cnt = 0; m_done = cyc; m_have = 1;
                        if (!m_rs) begin
                            m_hist = {m_hist[23:0], m_acc[7:0]};
                            if (m_hist == 32'h380C0106) e_init = 1;
                        end
                    end
                end
            end
            e_busy = m_have && (cyc - m_done) < BUSY;
        end
    end

    // compare process, away from the active edge
    initial forever begin
        @(negedge clk);
        chk("rx_valid", bus.rx_valid, e_valid);
        chk("frame_err", bus.frame_err, e_ferr);
        chk("overrun_err", bus.overrun_err, e_oerr);
        chk("rx_data", bus.rx_data, e_data);
        chk("rx_rs", bus.rx_rs, e_rs);
        chk("busy", bus.busy, e_busy);
        chk("init_seen", bus.init_seen, e_init);
        nv += int'(bus.rx_valid);
        nf += int'(bus.frame_err);
        no += int'(bus.overrun_err);
        if (bus.busy) run++;
        else if (run > 0) begin last_run = run; run = 0; end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_bit(input logic v, input logic rs, input logic rw);
        bus.lcddat = v; bus.lcdrs = rs; bus.lcdrw = rw; bus.lcde = 1'b1;
        @(posedge clk); #1;
        bus.lcde = 1'b0; ev_bit = v; ev_rs = rs; ev_rw = rw; ev = 1'b1;
        @(posedge clk); #1;
        ev = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs);
        for (int i = 7; i >= 0; i--) send_bit(b[i], rs, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(2);
    endtask

    initial begin
        int v0, f0, o0;
        logic [7:0] b, seq;
        logic rs;
        bus.lcde = 1'b0; bus.lcdrs = 1'b0; bus.lcdrw = 1'b0; bus.lcddat = 1'b0;
        idle(4);
        chk("reset rx_data", bus.rx_data, 8'h00);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset init_seen", bus.init_seen, 1'b0);
        reset = 1'b1;
        idle(3);

        v0 = nv;
        send_byte(8'hA5, 1'b1);
        idle(45);
        chk("A5 pulses", nv - v0, 1);
        chk("A5 data", bus.rx_data, 8'hA5);
        chk("A5 model data", e_data, 8'hA5);
        chk("A5 rs", bus.rx_rs, 1'b1);
        chk("A5 busy length", last_run, 40);

        seq = 8'h38; send_byte(seq, 1'b0); idle(45);
        send_byte(8'h0C, 1'b0); idle(45);
        send_byte(8'h01, 1'b0); idle(45);
        chk("init before last", bus.init_seen, 1'b0);
        send_byte(8'h06, 1'b0); idle(45);
        chk("init seen", bus.init_seen, 1'b1);
        pulse_reset();
        chk("init cleared", bus.init_seen, 1'b0);
        send_byte(8'h38, 1'b0); idle(45);
        send_byte(8'h38, 1'b0); idle(45);
        send_byte(8'h0C, 1'b0); idle(45);
        send_byte(8'h01, 1'b0); idle(45);
        chk("init repeat before last", bus.init_seen, 1'b0);
        send_byte(8'h06, 1'b0); idle(45);
        chk("init repeat seen", bus.init_seen, 1'b1);

        f0 = nf;
        send_bit(1'b1, 1'b0, 1'b0); send_bit(1'b0, 1'b0, 1'b0); send_bit(1'b1, 1'b0, 1'b0);
        idle(1100);
        chk("timeout pulses", nf - f0, 1);
        send_byte(8'h3C, 1'b0); idle(45);
        chk("after timeout data", bus.rx_data, 8'h3C);

        o0 = no;
        send_byte(8'h11, 1'b0);
        idle(3);
        send_bit(1'b1, 1'b0, 1'b0);
        idle(45);
        chk("busy overrun pulses", no - o0, 1);
        send_byte(8'h5A, 1'b1); idle(45);
        chk("after overrun data", bus.rx_data, 8'h5A);

        v0 = nv; f0 = nf;
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 4, 1'b0);
        idle(5);
        chk("rs clash ferr", nf - f0, 1);
        chk("rs clash no valid", nv - v0, 0);
        o0 = no;
        send_bit(1'b1, 1'b0, 1'b0); send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        for (int i = 5; i >= 0; i--) send_bit(i == 1 || i == 0, 1'b0, 1'b0);
        idle(45);
        chk("rw overrun pulses", no - o0, 1);
        chk("rw count kept", bus.rx_data, 8'hC3);

        v0 = nv; f0 = nf; o0 = no;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        idle(2);
        chk("mid reset rx_data", bus.rx_data, 8'h00);
        chk("mid reset init", bus.init_seen, 1'b0);
        reset = 1'b1;
        idle(20);
        chk("mid reset no pulses", (nv - v0) + (nf - f0) + (no - o0), 0);
        send_byte(8'h81, 1'b0); idle(2);
        chk("after reset data", bus.rx_data, 8'h81);
        reset = 1'b0;
        idle(1);
        chk("busy reset", bus.busy, 1'b0);
        reset = 1'b1;
        idle(3);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: b = 8'h38;
                1: b = 8'h0C;
                2: b = 8'h01;
                default: b = 8'h06;
            endcase
            rs = 1'b0;
            if ($urandom_range(0, 9) < 6) begin
                b = 8'($urandom);
                rs = 1'($urandom);
            end
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i], ($urandom_range(0, 19) == 0) ? ~rs : rs, $urandom_range(0, 24) == 0);
                idle($urandom_range(0, 2));
            end
            idle($urandom_range(0, 60));
        end
        idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
